// File: rtl/seq_mult_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the sequential shift-and-add multiplier.
package seq_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Multiplier datapath: operand registers, accumulator, adder and right shifter.
module seq_mult_dp
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_nxt_o
);

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH:0]     sum;

    // sum[WIDTH] is the carry; it lands in acc[2*WIDTH-1] through the shift.
    always_comb begin
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (mplier_q[0]) begin
            sum = sum + {1'b0, mcand_q};
        end
        acc_d = {sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (load_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
        end else if (step_i) begin
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
        end
    end

    assign acc_nxt_o = acc_d;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: FSM, iteration counter and product register around seq_mult_dp.
module seq_mult_ctrl
    import seq_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2*WIDTH-1:0] acc_nxt;
    logic               load, step;

    seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .step_i    (step),
        .a_i       (a),
        .b_i       (b),
        .acc_nxt_o (acc_nxt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                // Last iteration: capture the post-shift accumulator directly.
                if (cnt_q == CNT_W'(1)) begin
                    product_d = acc_nxt;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl: expected products queued at issue, checked by a done-driven monitor.
module tb_seq_mult_ctrl;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a, b;
    logic               busy, done;
    logic [2*WIDTH-1:0] product;

    logic [2*WIDTH-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    seq_mult_ctrl #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got product %0d, expected no done", product);
            end else begin
                chk("product_at_done", 32'(product), 32'(exp_q.pop_front()));
            end
        end
    end

    // Waits at negedges after an accept edge; returns cycles until done (0 on timeout).
    task automatic wait_done(input string name, input bit chk_busy, output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
            if (chk_busy) chk({name, "_busy"}, 32'(busy), 32'd1);
        end
        if (n == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done, expected done within 40 cycles", name);
        end
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic [2*WIDTH-1:0] ev);
        int n;
        exp_q.push_back(ev);
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~av; b = ~bv;
        wait_done(name, 1'b1, n);
        chk({name, "_latency"}, 32'(n), 32'(WIDTH + 1));
        chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({name, "_done_drop"}, 32'(done), 32'd0);
        chk({name, "_held"}, 32'(product), 32'(ev));
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_product", 32'(product), 32'd0);
        end

        run_op("13x11", 8'd13, 8'd11, 16'h008F);
        run_op("255x255", 8'd255, 8'd255, 16'hFE01);
        run_op("128x2", 8'd128, 8'd2, 16'd256);
        run_op("0x200", 8'd0, 8'd200, 16'd0);
        run_op("1x0", 8'd1, 8'd0, 16'd0);
        run_op("1x1", 8'd1, 8'd1, 16'd1);

        // Interference during RUN, then re-accept from held start
        exp_q.push_back(16'd42);
        exp_q.push_back(16'd81);
        @(posedge clk); #1;
        a = 8'd7; b = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        a = 8'd9; b = 8'd9;
        wait_done("b2b_first", 1'b1, n);
        chk("b2b_first_latency", 32'(n), 32'(WIDTH + 1));
        @(posedge clk); #1;
        chk("b2b_ignored_in_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("b2b_second", 1'b1, n);
        chk("b2b_second_latency", 32'(n), 32'(WIDTH + 1));
        @(negedge clk);
        chk("b2b_held", 32'(product), 32'd81);

        // Reset abort on the 4th RUN edge
        @(posedge clk); #1;
        a = 8'd100; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (12) @(negedge clk);
        chk("abort_still_idle", 32'(busy), 32'd0);

        run_op("12x12", 8'd12, 8'd12, 16'd144);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
Sequential unsigned shift-and-add multiplier built from clocked registers, with a start/done handshake.
- A small FSM plus iteration counter sequences a WIDTH-bit multiplicand register, a multiplier shift register and a 2*WIDTH-bit accumulator, one partial product per clock.
- Used by the ALU/processor datapath wherever a multi-cycle multiply is acceptable in place of an array multiplier.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on posedge clk
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand, captured on the accepting edge
b  input  WIDTH  multiplier, captured on the accepting edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when product becomes valid
product  output  2*WIDTH  registered result; held until next completion

Behaviour:
- Reset, sampled on posedge clk with rst=1:
  - state=IDLE; busy=0, done=0, product=0.
  - Internal registers (multiplicand, multiplier, accumulator, carry, counter) cleared.
  - rst has priority over every other input in every state.
- States: IDLE, RUN, DONE. Encoding is 2 bits; the unused code goes to IDLE.
- IDLE:
  - If start=1: capture a into mcand and b into mplier; acc=0, carry=0, cnt=WIDTH; go to RUN.
  - If start=0: stay in IDLE.
  - product keeps its previous value.
- RUN, one iteration per edge:
  - If mplier[0]=1: {carry, acc_hi} = acc_hi + mcand, computed as a (WIDTH+1)-bit sum. Otherwise carry=0 and acc_hi is unchanged.
  - Then shift right by one: {carry, acc} is shifted so the carry enters acc[2*WIDTH-1]. mplier also shifts right by one.
  - cnt decrements by 1. When cnt reaches 0 after the decrement (the WIDTH-th RUN edge), go to DONE and load product with the final acc on that same edge.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - Next edge returns unconditionally to IDLE. start seen while in DONE is ignored; the requester must hold or re-assert it in IDLE.
- Latency:
  - Accept edge E0; RUN edges E1..EWIDTH.
  - done is high in the cycle after EWIDTH.
  - Start-to-done is WIDTH+1 edges (9 for WIDTH=8). Minimum back-to-back spacing is WIDTH+2 cycles.
- busy is high from the cycle after E0 through the cycle ending at EWIDTH.
- start, a and b are ignored while busy. Operands may change freely after the accept edge.
- Arithmetic: all unsigned. The result is exact for all inputs, including the carry on the maximal case (2^WIDTH-1)^2.
- Reset mid-RUN aborts with no done pulse. product is cleared to 0, not kept.
- No combinational path from inputs to outputs; all outputs are registered or decoded from state.

Decomposition:
- Shared header/package:
  - state localparams S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10.
  - CNT_W = $clog2(WIDTH+1).
- One natural sub-module, seq_mult_dp:
  - Contents: mcand, mplier, acc and carry registers, the adder and the shifter.
  - Controls: load and step enables, both driven from the FSM in seq_mult_ctrl.
  - Reset: same clk and synchronous rst.
- The counter and FSM stay in the top module.

Test Plan:
1. Assert rst for 2 cycles, then release with start=0 for 5 cycles -> busy=0, done=0, product=0 throughout.
2. WIDTH=8; a=13, b=11, start pulsed one cycle -> busy high 8 cycles; done high in cycle 9 after the accept edge; product=143 (0x008F), held after done drops.
3. a=255, b=255 -> product=65025 (0xFE01); exercises the carry into bit 15. Then a=128, b=2 -> product=256.
4. a=0, b=200 -> product=0. Then a=1, b=0 -> product=0. Then a=1, b=1 -> product=1; done pulses once per operation.
5. Interference and back-to-back:
   - a=7, b=6 accepted, then start=1 with a=9, b=9 held throughout RUN -> first result is 42, not 81.
   - With start still held: IDLE re-accepts a=9, b=9 two cycles after done; product becomes 81 after the next WIDTH+1 edges.
6. Reset abort and recovery:
   - a=100, b=3 accepted; rst=1 on the 4th RUN edge -> next cycle busy=0, product=0, no done pulse.
   - Then a=12, b=12 -> product=144 with normal latency.
